// File: rtl/demux_3b_3output_pkg.sv
// Shared definitions for the accumulator datapath's 3-way source mux and return-path demux.
package demux_3b_3output_pkg;

    localparam int unsigned OP_W     = 2;
    localparam int unsigned NUM_DEST = 3;

    localparam logic [OP_W-1:0] OP_A     = 2'b00;
    localparam logic [OP_W-1:0] OP_B     = 2'b01;
    localparam logic [OP_W-1:0] OP_C     = 2'b10;
    localparam logic [OP_W-1:0] OP_C_ALT = 2'b11;

    // One-hot destination select: bit 0 = A, bit 1 = B, bit 2 = C.
    function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [OP_W-1:0] op);
        logic [NUM_DEST-1:0] sel;
        sel = '0;
        case (op)
            OP_A:           sel = 3'b001;
            OP_B:           sel = 3'b010;
            OP_C, OP_C_ALT: sel = 3'b100;
            default:        sel = 3'b100;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/demux_3b_3output_fifo.sv
// Synchronous FIFO holding {op, data} entries; full/empty are derived from the occupancy count.
module demux_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Guard both strobes so the count can neither overflow nor underflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_ok  = push && (count_q < CNT_W'(DEPTH));
        pop_ok   = pop && (count_q != '0);

        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/demux_3b_3output.sv
// Buffered 1-to-3 result demux: queues {Op, In_data} and delivers each entry, in order, to A, B or C.
module demux_3b_3output
    import demux_3b_3output_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   Rst_n,
    input  logic [WIDTH-1:0]       In_data,
    input  logic [OP_W-1:0]        Op,
    input  logic                   In_valid,
    output logic                   In_ready,
    output logic [WIDTH-1:0]       A,
    output logic [WIDTH-1:0]       B,
    output logic [WIDTH-1:0]       C,
    output logic                   A_valid,
    output logic                   B_valid,
    output logic                   C_valid,
    input  logic                   A_ready,
    input  logic                   B_ready,
    input  logic                   C_ready,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int unsigned ENTRY_W = WIDTH + OP_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0]  head;
    logic [WIDTH-1:0]    head_data;
    logic [OP_W-1:0]     head_op;
    logic [NUM_DEST-1:0] dest_sel;
    logic                fifo_push;
    logic                fifo_pop;

    demux_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (Rst_n),
        .push  (fifo_push),
        .wdata ({Op, In_data}),
        .pop   (fifo_pop),
        .rdata (head),
        .count (Count)
    );

    // Ready depends only on stored occupancy, so a full FIFO never passes through on a pop.
    assign In_ready  = (Count < CNT_W'(DEPTH));
    assign fifo_push = In_valid && In_ready;

    assign head_op   = head[ENTRY_W-1 -: OP_W];
    assign head_data = head[WIDTH-1:0];

    // Steer the head to its one destination; a ready on any other port is ignored.
    always_comb begin
        dest_sel = '0;
        A        = '0;
        B        = '0;
        C        = '0;
        if (Count != '0) begin
            dest_sel = dest_onehot(head_op);
        end
        A_valid  = dest_sel[0];
        B_valid  = dest_sel[1];
        C_valid  = dest_sel[2];
        if (dest_sel[0]) A = head_data;
        if (dest_sel[1]) B = head_data;
        if (dest_sel[2]) C = head_data;
        fifo_pop = |(dest_sel & {C_ready, B_ready, A_ready});
    end

endmodule

// File: tb/tb_demux_3b_3output.sv
// Self-checking bench for demux_3b_3output: queue reference model plus directed and random traffic.
module tb_demux_3b_3output;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned DEPTH = 2;

    logic             CLK = 1'b0;
    logic             Rst_n = 1'b1;
    logic [WIDTH-1:0] In_data = '0;
    logic [1:0]       Op = '0;
    logic             In_valid = 1'b0;
    logic             In_ready;
    logic [WIDTH-1:0] A, B, C;
    logic             A_valid, B_valid, C_valid;
    logic             A_ready = 1'b0, B_ready = 1'b0, C_ready = 1'b0;
    logic [1:0]       Count;

    int tests = 0;
    int fails = 0;

    // Reference queue: each entry is {op, data}, oldest at index 0.
    logic [4:0] q[$];

    demux_3b_3output #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .Rst_n    (Rst_n),
        .In_data  (In_data),
        .Op       (Op),
        .In_valid (In_valid),
        .In_ready (In_ready),
        .A        (A),
        .B        (B),
        .C        (C),
        .A_valid  (A_valid),
        .B_valid  (B_valid),
        .C_valid  (C_valid),
        .A_ready  (A_ready),
        .B_ready  (B_ready),
        .C_ready  (C_ready),
        .Count    (Count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dest_of(input logic [1:0] op);
        return (op == 2'd0) ? 0 : (op == 2'd1) ? 1 : 2;
    endfunction

    // Model update: pop if the head's own destination is ready, push if there was room before the edge.
    always @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            q.delete();
        end else begin
            int  sz;
            bit  do_pop;
            bit  do_push;
            logic [2:0] rdy;
            sz      = q.size();
            rdy     = {C_ready, B_ready, A_ready};
            do_pop  = (sz != 0) && rdy[dest_of(q[0][4:3])];
            do_push = In_valid && (sz < int'(DEPTH));
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({Op, In_data});
        end
    end

    // Every cycle, outputs must match what the model's head implies.
    always @(negedge CLK) begin
        logic [2:0] exp_v;
        logic [8:0] exp_bus;
        exp_v   = '0;
        exp_bus = '0;
        if (q.size() != 0) begin
            exp_v[dest_of(q[0][4:3])] = 1'b1;
            case (dest_of(q[0][4:3]))
                0:       exp_bus[8:6] = q[0][2:0];
                1:       exp_bus[5:3] = q[0][2:0];
                default: exp_bus[2:0] = q[0][2:0];
            endcase
        end
        check("model_count", 32'(Count), 32'(q.size()));
        check("model_in_ready", 32'(In_ready), 32'(q.size() < int'(DEPTH)));
        check("model_valids", 32'({A_valid, B_valid, C_valid}), 32'({exp_v[0], exp_v[1], exp_v[2]}));
        check("model_buses", 32'({A, B, C}), 32'(exp_bus));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] d, input logic [1:0] op);
        In_valid = v;
        In_data  = d;
        Op       = op;
    endtask

    initial begin
        // 1. Reset held with a pending offer.
        #1 Rst_n = 1'b0;
        drive(1'b1, 3'b101, 2'b00);
        A_ready = 1'b1; B_ready = 1'b1; C_ready = 1'b1;
        repeat (3) tick();
        check("rst_count", 32'(Count), 0);
        check("rst_valids", 32'({A_valid, B_valid, C_valid}), 0);
        check("rst_buses", 32'({A, B, C}), 0);
        check("rst_in_ready", 32'(In_ready), 1);
        drive(1'b0, 3'b000, 2'b00);
        Rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'({A_valid, B_valid, C_valid}), 0);

        // 2. Routing through all four op codes, one per cycle.
        drive(1'b1, 3'b101, 2'b00); tick();
        check("route_a", 32'({A_valid, A, B, C}), 32'({1'b1, 3'd5, 3'd0, 3'd0}));
        drive(1'b1, 3'b010, 2'b01); tick();
        check("route_b", 32'({B_valid, A, B, C}), 32'({1'b1, 3'd0, 3'd2, 3'd0}));
        drive(1'b1, 3'b111, 2'b10); tick();
        check("route_c10", 32'({C_valid, A, B, C}), 32'({1'b1, 3'd0, 3'd0, 3'd7}));
        drive(1'b1, 3'b011, 2'b11); tick();
        check("route_c11", 32'({C_valid, A, B, C}), 32'({1'b1, 3'd0, 3'd0, 3'd3}));
        drive(1'b0, 3'b000, 2'b00); tick();
        check("route_drained", 32'(Count), 0);

        // 3. Full FIFO with a stalled A head.
        A_ready = 1'b0;
        drive(1'b1, 3'b001, 2'b00); tick();
        drive(1'b1, 3'b110, 2'b01); tick();
        check("full_count", 32'(Count), 2);
        check("full_in_ready", 32'(In_ready), 0);
        check("full_b_blocked", 32'(B_valid), 0);
        drive(1'b1, 3'b100, 2'b00); tick();
        check("full_ignored", 32'({Count, A_valid, A}), 32'({2'd2, 1'b1, 3'd1}));
        drive(1'b0, 3'b000, 2'b00);
        A_ready = 1'b1; tick();
        check("full_then_b", 32'({B_valid, B, Count}), 32'({1'b1, 3'd6, 2'd1}));
        tick();
        check("full_no_stale", 32'({Count, A_valid, B_valid, C_valid}), 0);

        // 4. Push and pop on the same edge.
        drive(1'b1, 3'b010, 2'b10); tick();
        A_ready = 1'b0;
        drive(1'b1, 3'b100, 2'b00); tick();
        check("pushpop_count", 32'(Count), 1);
        check("pushpop_new", 32'({A_valid, A}), 32'({1'b1, 3'd4}));
        drive(1'b0, 3'b000, 2'b00);
        A_ready = 1'b1; tick();

        // 5. Readies on other ports must not pop a B head.
        B_ready = 1'b0;
        drive(1'b1, 3'b110, 2'b01); tick();
        drive(1'b0, 3'b000, 2'b00);
        repeat (5) tick();
        check("wrong_ready_hold", 32'({Count, B_valid, B}), 32'({2'd1, 1'b1, 3'd6}));
        B_ready = 1'b1; tick();
        check("wrong_ready_pop", 32'(Count), 0);

        // 6. Asynchronous reset with a full, stalled FIFO.
        B_ready = 1'b0;
        drive(1'b1, 3'b011, 2'b01); tick();
        drive(1'b1, 3'b101, 2'b01); tick();
        drive(1'b0, 3'b000, 2'b00);
        check("mid_rst_pre", 32'(Count), 2);
        #2 Rst_n = 1'b0;
        #1;
        check("mid_rst_async", 32'({Count, A_valid, B_valid, C_valid}), 0);
        tick(); tick();
        Rst_n = 1'b1;
        B_ready = 1'b1;
        tick(); tick();
        check("mid_rst_no_stale", 32'({Count, A_valid, B_valid, C_valid, A, B, C}), 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom), 2'($urandom));
            A_ready = ($urandom_range(0, 3) != 0);
            B_ready = ($urandom_range(0, 3) != 0);
            C_ready = ($urandom_range(0, 3) != 0);
            if (i == 300) Rst_n = 1'b0;
            if (i == 303) Rst_n = 1'b1;
            tick();
        end
        drive(1'b0, 3'b000, 2'b00);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
